iob_bus_merge: RTL and testbench
================================

# iob_bus_merge

Round-robin N-to-1 merger for the native `req`/`resp` bus. It lets several bus masters share one memory-side slave, for example a CPU data bus and an accelerator data bus both driving the external-memory data port. It sits directly upstream of that slave, taking the place of a direct master-to-slave connection. It keeps one transaction outstanding at a time and holds the grant until the slave answers with `ready`.

## Interface
- `N_MASTERS`, default 2: number of requesting masters (2..8).
- `ADDR_W`, default 32: request address width.
- `DATA_W`, default 32: data width. Strobe width is `DATA_W/8`.
- Request word layout (MSB first): `{valid, addr[ADDR_W], wdata[DATA_W], wstrb[DATA_W/8]}`.
- Response word layout (MSB first): `{rdata[DATA_W], ready}`.
- `clk`  in  1  system clock. All state is on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `m_req`  in  `N_MASTERS*REQ_W`  packed master requests. Master i occupies slice i.
- `m_resp`  out  `N_MASTERS*RESP_W`  packed master responses. Master i occupies slice i.
- `s_req`  out  `REQ_W`  request to the slave.
- `s_resp`  in  `RESP_W`  response from the slave.

## Operation
- FSM states:
  - IDLE: no grant.
  - BUSY: grant register `gnt` (index width `$clog2(N_MASTERS)`) selects the master being served.
- IDLE:
  - `s_req` is all-zero.
  - If any master `valid` is high, pick the first requester scanning `last+1, last+2, …` modulo `N_MASTERS`.
  - Register the pick into `gnt` and move to BUSY.
- BUSY:
  - `s_req = m_req[gnt]`, passed through combinationally, so slave `valid` follows the granted master's `valid`.
  - `m_resp[gnt] = s_resp`.
  - Every other master's response slice is 0.
  - On `s_resp.ready = 1`: set `last <= gnt` and return to IDLE.
- A request that is not granted waits. Its `ready` stays 0 and its `valid` must stay high (native-bus rule).
- Only the granted slot ever sees `ready`. A slave `ready` arriving in IDLE is dropped and no master gets it.
- A granted master that deasserts `valid` before `ready` is a protocol violation. The block stays in BUSY, and the bench flags it with an assertion.
- Reset (asynchronous, any cycle, including mid-BUSY):
  - State goes to IDLE, `gnt = 0`, `last = N_MASTERS-1`, so master 0 wins first.
  - All outputs go to 0.
  - Any in-flight slave transaction is abandoned. The slave is reset on the same net.

## Timing
- Arbitration latency: 1 cycle. A master raising `valid` in cycle t with the block in IDLE is seen by the slave in cycle t+1.
- The response is combinational slave-to-master. `ready` reaches the master in the same cycle the slave asserts it.
- Minimum transaction occupancy is 2 cycles, one IDLE and one BUSY, when the slave answers in the first BUSY cycle.
- Back-to-back requests always pass through one IDLE cycle. Sustained throughput is 1 transaction per (slave latency + 1) cycles.
- Fairness: with all N masters requesting continuously, each is served exactly once in every N grants, in order `last+1 … last+N`.
- Simultaneous events:
  - Slave `ready` and a new request from the same master in the same cycle: that master re-enters arbitration in the next IDLE. It ranks last under round-robin.
  - A `ready` in the cycle reset releases is ignored.

## Structure
- Field widths and offsets (`REQ_W`, `RESP_W`, `V_BIT`, `A_BIT`, `WDATA_BIT`, `WSTRB_BIT`, `RDATA_BIT`, `READY_BIT`) come from the shared interconnect header. The block defines none of its own.
- The FSM state encoding is local to the block.
- Sub-module `rr_pick`, purely combinational:
  - Inputs: N-bit request vector and the `last` index.
  - Outputs: a grant index and an `any` flag.
  - Verified standalone.
- Top-level responsibilities: FSM, `gnt`/`last` registers, request mux, response demux.

## Test plan
- Reset, then a single read from master 0 at `0x100`, slave `ready` after 3 cycles with `rdata = 0xDEADBEEF`:
  - `s_req.valid` rises 1 cycle after master valid.
  - Master 0 gets `0xDEADBEEF` with `ready` in the same cycle as the slave.
  - Master 1 sees `ready = 0` throughout.
- Masters 0 and 1 both request continuously for 6 transactions: grants alternate 0, 1, 0, 1, 0, 1, with one IDLE cycle between each.
- `N_MASTERS = 4`, only masters 1 and 3 requesting: grant order is 1, 3, 1, 3. Masters 0 and 2 never receive `ready`.
- Write from master 1 with `wstrb = 0x3` and `wdata = 0x12345678`: the slave sees exactly those fields and `addr` unmodified.
- Assert `rst` low mid-BUSY while serving master 1:
  - All outputs are 0 immediately.
  - After release, a request from master 1 and master 0 together is granted to master 0 first.
- Slave asserts a spurious `ready` in IDLE: no master sees `ready`, and the state stays IDLE.

Source files
------------

// File: rtl/iob_bus_merge_pkg.sv
// Native req/resp bus field layout shared by interconnect blocks, plus the merger FSM encoding.
// Layouts are parameterised by address/data width, so they are exposed as constant functions.
package iob_bus_merge_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } merge_state_t;

  // Request word, MSB first: {valid, addr, wdata, wstrb}
  function automatic int iob_req_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  function automatic int iob_v_bit(input int addr_w, input int data_w);
    return addr_w + data_w + data_w / 8;
  endfunction

  function automatic int iob_a_bit(input int data_w);
    return data_w + data_w / 8;
  endfunction

  function automatic int iob_wdata_bit(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int iob_wstrb_bit();
    return 0;
  endfunction

  // Response word, MSB first: {rdata, ready}
  function automatic int iob_resp_w(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int iob_rdata_bit();
    return 1;
  endfunction

  function automatic int iob_ready_bit();
    return 0;
  endfunction

endpackage

// File: rtl/iob_bus_merge_rr_pick.sv
// Combinational round-robin picker: first set request scanning last+1, last+2, ... modulo N.
module iob_bus_merge_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] gnt,
  output logic             any
);

  // Walk from the lowest priority (last itself) up to last+1 so the highest priority hit wins.
  always_comb begin
    int idx;
    gnt = '0;
    any = |req;
    for (int i = N; i >= 1; i--) begin
      idx = (int'(last) + i) % N;
      if (req[idx]) gnt = IDX_W'(idx);
    end
  end

endmodule

// File: rtl/iob_bus_merge.sv
// Round-robin N-to-1 merger for the native req/resp bus; one transaction in flight,
// grant held until the slave returns ready.
//
// state   | meaning
// ST_IDLE | no grant, s_req forced to 0, arbitrating among valid masters
// ST_BUSY | gnt_q selects the served master; request muxed out, response demuxed back
module iob_bus_merge
  import iob_bus_merge_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [N_MASTERS*iob_req_w(ADDR_W, DATA_W)-1:0] m_req,
  output logic [N_MASTERS*iob_resp_w(DATA_W)-1:0]        m_resp,
  output logic [iob_req_w(ADDR_W, DATA_W)-1:0]           s_req,
  input  logic [iob_resp_w(DATA_W)-1:0]                  s_resp
);

  localparam int REQ_W     = iob_req_w(ADDR_W, DATA_W);
  localparam int RESP_W    = iob_resp_w(DATA_W);
  localparam int V_BIT     = iob_v_bit(ADDR_W, DATA_W);
  localparam int READY_BIT = iob_ready_bit();
  localparam int GNT_W     = $clog2(N_MASTERS);

  merge_state_t     state_q, state_d;
  logic [GNT_W-1:0] gnt_q, gnt_d;
  logic [GNT_W-1:0] last_q, last_d;
  logic [N_MASTERS-1:0] m_valid;
  logic [GNT_W-1:0] pick_gnt;
  logic             pick_any;
  logic             slave_ready;

  for (genvar g = 0; g < N_MASTERS; g++) begin : g_valid
    assign m_valid[g] = m_req[g*REQ_W + V_BIT];
  end

  assign slave_ready = s_resp[READY_BIT];

  iob_bus_merge_rr_pick #(
    .N     (N_MASTERS),
    .IDX_W (GNT_W)
  ) u_rr_pick (
    .req  (m_valid),
    .last (last_q),
    .gnt  (pick_gnt),
    .any  (pick_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= GNT_W'(N_MASTERS - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // A ready seen in IDLE is dropped: nothing is demuxed and the FSM ignores it.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    s_req   = '0;
    m_resp  = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_gnt;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int i = 0; i < N_MASTERS; i++) begin
          if (gnt_q == GNT_W'(i)) begin
            s_req                         = m_req[i*REQ_W +: REQ_W];
            m_resp[i*RESP_W +: RESP_W]    = s_resp;
          end
        end
        if (slave_ready) begin
          last_d  = gnt_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_iob_bus_merge.sv
// Directed bench for iob_bus_merge: a 2-master and a 4-master instance, hand-computed expectations.
module tb_iob_bus_merge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int RW = 1 + AW + DW + SW;
  localparam int PW = DW + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [2*RW-1:0] m_req2  = '0;
  logic [2*PW-1:0] m_resp2;
  logic [RW-1:0]   s_req2;
  logic [PW-1:0]   s_resp2 = '0;

  logic [4*RW-1:0] m_req4  = '0;
  logic [4*PW-1:0] m_resp4;
  logic [RW-1:0]   s_req4;
  logic [PW-1:0]   s_resp4 = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  iob_bus_merge #(.N_MASTERS(2), .ADDR_W(AW), .DATA_W(DW)) u_dut2 (
    .clk(clk), .rst(rst), .m_req(m_req2), .m_resp(m_resp2), .s_req(s_req2), .s_resp(s_resp2)
  );

  iob_bus_merge #(.N_MASTERS(4), .ADDR_W(AW), .DATA_W(DW)) u_dut4 (
    .clk(clk), .rst(rst), .m_req(m_req4), .m_resp(m_resp4), .s_req(s_req4), .s_resp(s_resp4)
  );

  function automatic logic [RW-1:0] mk_req(input logic [31:0] a, input logic [31:0] d,
                                           input logic [3:0] s);
    return {1'b1, a, d, s};
  endfunction

  function automatic logic [PW-1:0] mk_resp(input logic [31:0] d);
    return {d, 1'b1};
  endfunction

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    m_req2  = '0;
    m_req4  = '0;
    s_resp2 = '0;
    s_resp4 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Native-bus rule: a master holding valid without ready must keep valid high.
  logic [5:0] v_q, r_q;
  logic       rst_q = 1'b0;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      if (rst && rst_q && v_q[i] && !r_q[i])
        assert (m_req2[i*RW + RW-1]) else $error("FAIL protocol: m2 master %0d dropped valid", i);
    for (int i = 0; i < 4; i++)
      if (rst && rst_q && v_q[i+2] && !r_q[i+2])
        assert (m_req4[i*RW + RW-1]) else $error("FAIL protocol: m4 master %0d dropped valid", i);
    rst_q <= rst;
    for (int i = 0; i < 2; i++) begin
      v_q[i] <= m_req2[i*RW + RW-1];
      r_q[i] <= m_resp2[i*PW];
    end
    for (int i = 0; i < 4; i++) begin
      v_q[i+2] <= m_req4[i*RW + RW-1];
      r_q[i+2] <= m_resp4[i*PW];
    end
  end

  initial begin
    logic [2*PW-1:0] e2;
    logic [4*PW-1:0] e4;
    int exp_m;
    int order4 [4];
    order4 = '{1, 3, 1, 3};

    // Reset holds all outputs at 0 even with a live request and slave ready.
    rst     = 1'b0;
    m_req2  = {{RW{1'b0}}, mk_req(32'h100, 32'h0, 4'h0)};
    s_resp2 = mk_resp(32'hDEADBEEF);
    #3;
    check_val("rst_s_req", s_req2, '0);
    check_val("rst_m_resp", m_resp2, '0);
    check_val("rst_s_req4", s_req4, '0);

    // Single read from master 0, slave answers in the third BUSY cycle.
    do_reset();
    m_req2 = {{RW{1'b0}}, mk_req(32'h100, 32'h0, 4'h0)};
    #4;
    check_val("rd_idle_valid", s_req2[RW-1], 1'b0);
    step();
    #4;
    check_val("rd_busy_s_req", s_req2, mk_req(32'h100, 32'h0, 4'h0));
    check_val("rd_wait1_resp", m_resp2, '0);
    step();
    #4;
    check_val("rd_wait2_resp", m_resp2, '0);
    step();
    s_resp2 = mk_resp(32'hDEADBEEF);
    #4;
    check_val("rd_m0_resp", m_resp2[PW-1:0], mk_resp(32'hDEADBEEF));
    check_val("rd_m1_resp", m_resp2[2*PW-1:PW], '0);
    step();
    s_resp2 = '0;
    m_req2  = '0;
    #4;
    check_val("rd_after_idle", s_req2, '0);

    // Two masters requesting continuously alternate, one IDLE cycle between grants.
    do_reset();
    m_req2 = {mk_req(32'h2000, 32'h0, 4'h0), mk_req(32'h1000, 32'h0, 4'h0)};
    for (int k = 0; k < 6; k++) begin
      #4;
      check_val($sformatf("rr2_idle%0d", k), s_req2, '0);
      step();
      s_resp2 = mk_resp(32'(k));
      exp_m   = k % 2;
      #4;
      e2 = '0;
      e2[exp_m*PW +: PW] = mk_resp(32'(k));
      check_val($sformatf("rr2_resp%0d", k), m_resp2, e2);
      check_val($sformatf("rr2_addr%0d", k), s_req2[RW-2 -: AW],
                (exp_m == 0) ? 32'h1000 : 32'h2000);
      step();
      s_resp2 = '0;
    end

    // Four masters, only 1 and 3 request: 1,3,1,3; masters 0 and 2 never see ready.
    do_reset();
    m_req4[1*RW +: RW] = mk_req(32'h1111, 32'h0, 4'h0);
    m_req4[3*RW +: RW] = mk_req(32'h3333, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      #4;
      check_val($sformatf("rr4_idle%0d", k), s_req4, '0);
      step();
      s_resp4 = mk_resp(32'hA0 + 32'(k));
      #4;
      e4 = '0;
      e4[order4[k]*PW +: PW] = mk_resp(32'hA0 + 32'(k));
      check_val($sformatf("rr4_resp%0d", k), m_resp4, e4);
      step();
      s_resp4 = '0;
    end

    // Write from master 1 passes addr, wdata and wstrb through untouched.
    do_reset();
    m_req2 = {mk_req(32'hABC0, 32'h12345678, 4'h3), {RW{1'b0}}};
    #4;
    check_val("wr_idle", s_req2, '0);
    step();
    s_resp2 = mk_resp(32'h0);
    #4;
    check_val("wr_s_req", s_req2, mk_req(32'hABC0, 32'h12345678, 4'h3));
    check_val("wr_addr", s_req2[RW-2 -: AW], 32'hABC0);
    check_val("wr_wdata", s_req2[SW +: DW], 32'h12345678);
    check_val("wr_wstrb", s_req2[SW-1:0], 4'h3);
    e2 = '0;
    e2[PW +: PW] = mk_resp(32'h0);
    check_val("wr_resp", m_resp2, e2);
    step();
    s_resp2 = '0;
    m_req2  = '0;

    // Reset mid-BUSY while serving master 1; afterwards master 0 wins.
    m_req2 = {mk_req(32'h2000, 32'h0, 4'h0), {RW{1'b0}}};
    step();
    #2;
    check_val("mid_busy_valid", s_req2[RW-1], 1'b1);
    rst     = 1'b0;
    s_resp2 = mk_resp(32'hCAFE0000);
    #1;
    check_val("mid_rst_s_req", s_req2, '0);
    check_val("mid_rst_m_resp", m_resp2, '0);
    step();
    rst    = 1'b1;
    m_req2 = {mk_req(32'h2000, 32'h0, 4'h0), mk_req(32'h1000, 32'h0, 4'h0)};
    #1;
    check_val("rel_ready_drop", m_resp2, '0);
    check_val("rel_s_req", s_req2, '0);
    step();
    s_resp2 = mk_resp(32'h5A5A5A5A);
    #4;
    check_val("post_rst_gnt", s_req2, mk_req(32'h1000, 32'h0, 4'h0));
    e2 = '0;
    e2[0 +: PW] = mk_resp(32'h5A5A5A5A);
    check_val("post_rst_resp", m_resp2, e2);

    // Spurious ready in IDLE reaches nobody and does not start a transaction.
    do_reset();
    s_resp2 = mk_resp(32'hFFFFFFFF);
    #4;
    check_val("spur_m_resp", m_resp2, '0);
    check_val("spur_s_req", s_req2, '0);
    step();
    s_resp2 = '0;
    m_req2  = {{RW{1'b0}}, mk_req(32'h40, 32'h0, 4'h0)};
    #4;
    check_val("spur_still_idle", s_req2, '0);
    step();
    s_resp2 = mk_resp(32'h77);
    #4;
    check_val("spur_next_gnt", s_req2, mk_req(32'h40, 32'h0, 4'h0));
    check_val("spur_next_resp", m_resp2, {{PW{1'b0}}, mk_resp(32'h77)});
    step();
    s_resp2 = '0;
    m_req2  = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
